// File: rtl/dma_engineer_if.sv
// Purpose: bundles the weight-fetch request channel, the returned-word stream and the memory read port.
// Latency: none, wiring only.
// Backpressure: none on the word stream; the memory read port is throttled by mem_rd_rdy.
//
// Signals:
//   dma_engineer_req / _start_addr / _length  request from the layer controller
//   dma_engineer_ack                          one-cycle accept pulse
//   dma_engineer_dout / _dout_en / _dout_eop  returned words, last-word marker
//   mem_rd_en / _addr / _rdy                  read issue to memory
//   mem_rd_dout / _dout_en                    in-order read data from memory
// Modports: slave = the DMA responder, master = requester plus memory.
interface dma_engineer_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int LEN_WIDTH  = 27,
  parameter int DATA_WIDTH = 16
);
  logic                  dma_engineer_req;
  logic [ADDR_WIDTH-1:0] dma_engineer_start_addr;
  logic [LEN_WIDTH-1:0]  dma_engineer_length;
  logic                  dma_engineer_ack;
  logic [DATA_WIDTH-1:0] dma_engineer_dout;
  logic                  dma_engineer_dout_en;
  logic                  dma_engineer_dout_eop;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_rd_rdy;
  logic [DATA_WIDTH-1:0] mem_rd_dout;
  logic                  mem_rd_dout_en;

  modport slave (
    input  dma_engineer_req, dma_engineer_start_addr, dma_engineer_length,
    input  mem_rd_rdy, mem_rd_dout, mem_rd_dout_en,
    output dma_engineer_ack, dma_engineer_dout, dma_engineer_dout_en, dma_engineer_dout_eop,
    output mem_rd_en, mem_rd_addr
  );

  modport master (
    output dma_engineer_req, dma_engineer_start_addr, dma_engineer_length,
    output mem_rd_rdy, mem_rd_dout, mem_rd_dout_en,
    input  dma_engineer_ack, dma_engineer_dout, dma_engineer_dout_en, dma_engineer_dout_eop,
    input  mem_rd_en, mem_rd_addr
  );
endinterface

// File: rtl/dma_engineer.sv
// Purpose: weight-fetch responder; turns one {addr,len} request into pipelined memory reads and a word stream.
// Latency: ack 1 cycle after req; first read in the ack cycle; each memory return appears on dout 1 cycle later.
// Backpressure: none on dout; reads stall on mem_rd_rdy=0 or when MAX_OUTSTANDING reads are in flight.
//
// Ports:
//   i_clk, i_rst  clock and synchronous active-high reset
//   io_bus        dma_engineer_if.slave: request channel, word stream, memory read port
module dma_engineer #(
  parameter int ADDR_WIDTH      = 27,
  parameter int LEN_WIDTH       = 27,
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int OCNT_WIDTH      = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  dma_engineer_if.slave  io_bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [OCNT_WIDTH-1:0] LP_MAX_OCNT = OCNT_WIDTH'(MAX_OUTSTANDING);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issue_cnt;
  logic [LEN_WIDTH-1:0]  r_recv_cnt;
  logic [OCNT_WIDTH-1:0] r_ocnt;
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_en;
  logic                  r_dout_eop;

  logic                  w_start;
  logic                  w_rd_en;
  logic                  w_accept;
  logic                  w_ret;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Returns are only honoured in BUSY with reads in flight; anything else is a
  // stale return from before a reset and is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_rd_en     = 1'b0;
    w_accept    = 1'b0;
    w_ret       = 1'b0;
    // Counters are LEN_WIDTH wide so the full 2^27-1 length never overflows;
    // the address sum truncates, wrapping modulo 2^ADDR_WIDTH.
    w_rd_addr   = r_addr + ADDR_WIDTH'(r_issue_cnt);
    w_last      = (r_recv_cnt == (r_len - LEN_WIDTH'(1)));
    case (r_state)
      S_IDLE: begin
        w_start = io_bus.dma_engineer_req;
        if (w_start && (io_bus.dma_engineer_length != '0)) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_rd_en  = (r_issue_cnt < r_len) && (r_ocnt < LP_MAX_OCNT);
        w_accept = w_rd_en && io_bus.mem_rd_rdy;
        w_ret    = io_bus.mem_rd_dout_en && (r_ocnt != '0);
        if (w_ret && w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_ocnt      <= '0;
      r_ack       <= 1'b0;
      r_dout      <= '0;
      r_dout_en   <= 1'b0;
      r_dout_eop  <= 1'b0;
    end else begin
      r_ack <= w_start;
      if (w_start) begin
        r_addr      <= io_bus.dma_engineer_start_addr;
        r_len       <= io_bus.dma_engineer_length;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
      end else begin
        if (w_accept) r_issue_cnt <= r_issue_cnt + LEN_WIDTH'(1);
        if (w_ret)    r_recv_cnt  <= r_recv_cnt + LEN_WIDTH'(1);
      end
      // A same-cycle accept and return cancel out.
      case ({w_accept, w_ret})
        2'b10:   r_ocnt <= r_ocnt + OCNT_WIDTH'(1);
        2'b01:   r_ocnt <= r_ocnt - OCNT_WIDTH'(1);
        default: r_ocnt <= r_ocnt;
      endcase
      r_dout_en  <= w_ret;
      r_dout_eop <= w_ret && w_last;
      if (w_ret) r_dout <= io_bus.mem_rd_dout;
    end
  end

  assign io_bus.dma_engineer_ack      = r_ack;
  assign io_bus.dma_engineer_dout     = r_dout;
  assign io_bus.dma_engineer_dout_en  = r_dout_en;
  assign io_bus.dma_engineer_dout_eop = r_dout_eop;
  assign io_bus.mem_rd_en             = w_rd_en;
  assign io_bus.mem_rd_addr           = w_rd_addr;

endmodule

// File: tb/tb_dma_engineer.sv
// Purpose: self-checking bench for dma_engineer with an in-order latency memory model.
// Latency: memory returns each accepted read a programmable number of cycles later.
// Backpressure: mem_rd_rdy held high or toggled per vector.
module tb_dma_engineer;
  localparam int AW = 27;
  localparam int LW = 27;
  localparam int DW = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            lat;
    bit            tgl;
    int            exp_words;
    int            exp_peak;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_engineer_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)) bus ();

  dma_engineer #(
    .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(8), .OCNT_WIDTH(4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // memory model / monitor state
  logic [AW-1:0] q_addr[$];
  int            q_due[$];
  int            ncyc = 0;
  int            lat = 2;
  bit            rdy_tgl = 1'b0;
  int            inj_cnt = 0;
  int            tb_out = 0;
  int            peak = 0;
  int            iss = 0;
  int            acc = 0;
  int            ret = 0;
  int            addr_err = 0;
  int            cap_err = 0;
  int            words = 0;
  int            data_err = 0;
  int            eop_cnt = 0;
  int            eop_err = 0;
  int            first_out = -1;
  int            last_out = -1;
  logic [AW-1:0] cur_addr = '0;
  logic [LW-1:0] cur_len = '0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] ea;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a[15:0] ^ {5'b0, a[26:16]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats(input logic [AW-1:0] a, input logic [LW-1:0] l, input int lt, input bit tg);
    cur_addr  = a;
    cur_len   = l;
    lat       = lt;
    rdy_tgl   = tg;
    words     = 0;
    iss       = 0;
    peak      = tb_out;
    data_err  = 0;
    eop_cnt   = 0;
    eop_err   = 0;
    addr_err  = 0;
    cap_err   = 0;
    first_out = -1;
    last_out  = -1;
  endtask

  task automatic wait_eop(input string nm);
    for (int k = 0; k < 600 && eop_cnt == 0; k++) begin
      @(negedge clk); #1;
    end
    chk(nm, eop_cnt != 0, 1);
  endtask

  task automatic chk_outputs_zero(input string p);
    chk({p, "_ack"},      bus.dma_engineer_ack, 0);
    chk({p, "_dout"},     bus.dma_engineer_dout, 0);
    chk({p, "_dout_en"},  bus.dma_engineer_dout_en, 0);
    chk({p, "_eop"},      bus.dma_engineer_dout_eop, 0);
    chk({p, "_rd_en"},    bus.mem_rd_en, 0);
    chk({p, "_rd_addr"},  bus.mem_rd_addr, 0);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("v%0d", i);
    @(negedge clk); #1;
    clear_stats(v.addr, v.len, v.lat, v.tgl);
    bus.dma_engineer_req        = 1'b1;
    bus.dma_engineer_start_addr = v.addr;
    bus.dma_engineer_length     = v.len;
    @(negedge clk); #1;
    chk({p, "_ack"}, bus.dma_engineer_ack, 1);
    bus.dma_engineer_req = 1'b0;
    @(negedge clk); #1;
    chk({p, "_ack_pulse"}, bus.dma_engineer_ack, 0);
    if (v.exp_words > 0) wait_eop({p, "_done"});
    repeat (6) @(negedge clk);
    #1;
    chk({p, "_words"},    words, v.exp_words);
    chk({p, "_issued"},   iss, v.exp_words);
    chk({p, "_peak_out"}, peak, v.exp_peak);
    chk({p, "_data"},     data_err, 0);
    chk({p, "_eop_pos"},  eop_err, 0);
    chk({p, "_eop_cnt"},  eop_cnt, (v.exp_words > 0) ? 1 : 0);
    chk({p, "_addr_seq"}, addr_err, 0);
    chk({p, "_cap"},      cap_err, 0);
    if (v.exp_words > 0) begin
      chk({p, "_first_addr"}, first_addr, v.exp_first);
      chk({p, "_last_addr"},  last_addr, v.exp_last);
    end
  endtask

  // Memory model and output monitor: observes this cycle's outputs at the
  // falling edge, then drives the inputs the DUT will sample at the next rise.
  initial begin
    bus.mem_rd_rdy     = 1'b0;
    bus.mem_rd_dout    = '0;
    bus.mem_rd_dout_en = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.dma_engineer_dout_en === 1'b1) begin
        ea = cur_addr + AW'(words);
        if (bus.dma_engineer_dout !== mem_word(ea)) data_err++;
        if (bus.dma_engineer_dout_eop !== ((words == int'(cur_len) - 1) ? 1'b1 : 1'b0)) eop_err++;
        if (bus.dma_engineer_dout_eop === 1'b1) eop_cnt++;
        if (first_out < 0) first_out = ncyc;
        last_out = ncyc;
        words++;
      end else if (bus.dma_engineer_dout_eop !== 1'b0) begin
        eop_err++;
      end
      bus.mem_rd_rdy = rdy_tgl ? ((ncyc % 2) == 1) : 1'b1;
      ret = 0;
      if (q_due.size() > 0 && q_due[0] <= ncyc) begin
        bus.mem_rd_dout_en = 1'b1;
        bus.mem_rd_dout    = mem_word(q_addr.pop_front());
        void'(q_due.pop_front());
        ret = 1;
      end else if (inj_cnt > 0) begin
        bus.mem_rd_dout_en = 1'b1;
        bus.mem_rd_dout    = 16'hDEAD;
        inj_cnt--;
      end else begin
        bus.mem_rd_dout_en = 1'b0;
      end
      acc = (bus.mem_rd_en && bus.mem_rd_rdy) ? 1 : 0;
      if (bus.mem_rd_en === 1'b1 && tb_out >= 8) cap_err++;
      if (acc != 0) begin
        if (bus.mem_rd_addr !== cur_addr + AW'(iss)) addr_err++;
        if (iss == 0) first_addr = bus.mem_rd_addr;
        last_addr = bus.mem_rd_addr;
        iss++;
        q_addr.push_back(bus.mem_rd_addr);
        q_due.push_back(ncyc + lat);
      end
      tb_out = tb_out + acc - ret;
      if (tb_out > peak) peak = tb_out;
      ncyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    int   snap_words;
    int   snap_iss;
    bus.dma_engineer_req        = 1'b0;
    bus.dma_engineer_start_addr = '0;
    bus.dma_engineer_length     = '0;

    //        addr          len      lat tgl words peak first         last
    vt[0] = '{27'd1000,     27'd4,   2,  1'b0, 4,  2,   27'd1000,     27'd1003};
    vt[1] = '{27'h100,      27'd16,  20, 1'b0, 16, 8,   27'h100,      27'h10F};
    vt[2] = '{27'h100,      27'd16,  20, 1'b1, 16, 8,   27'h100,      27'h10F};
    vt[3] = '{27'h555,      27'd0,   2,  1'b0, 0,  0,   27'h0,        27'h0};
    vt[4] = '{27'd50,       27'd2,   3,  1'b0, 2,  2,   27'd50,       27'd51};
    vt[5] = '{27'h7FFFFFE,  27'd4,   2,  1'b0, 4,  2,   27'h7FFFFFE,  27'h0000001};
    vt[6] = '{27'h2000,     27'd1,   1,  1'b0, 1,  1,   27'h2000,     27'h2000};

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk_outputs_zero("reset");

    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    // Back-to-back: B is raised in A's eop cycle and must be acked next cycle.
    @(negedge clk); #1;
    clear_stats(27'h300, 27'd3, 2, 1'b0);
    bus.dma_engineer_req        = 1'b1;
    bus.dma_engineer_start_addr = 27'h300;
    bus.dma_engineer_length     = 27'd3;
    @(negedge clk); #1;
    chk("b2b_a_ack", bus.dma_engineer_ack, 1);
    bus.dma_engineer_req = 1'b0;
    for (int k = 0; k < 200 && bus.dma_engineer_dout_eop !== 1'b1; k++) begin
      @(negedge clk); #1;
    end
    chk("b2b_a_eop", bus.dma_engineer_dout_eop, 1);
    chk("b2b_a_words", words, 3);
    chk("b2b_a_data", data_err, 0);
    clear_stats(27'h4000, 27'd5, 2, 1'b0);
    bus.dma_engineer_req        = 1'b1;
    bus.dma_engineer_start_addr = 27'h4000;
    bus.dma_engineer_length     = 27'd5;
    @(negedge clk); #1;
    chk("b2b_b_ack", bus.dma_engineer_ack, 1);
    bus.dma_engineer_req = 1'b0;
    wait_eop("b2b_b_done");
    repeat (4) @(negedge clk);
    #1;
    chk("b2b_b_words", words, 5);
    chk("b2b_b_data", data_err, 0);
    chk("b2b_b_eop", eop_err, 0);
    chk("b2b_b_contig", last_out - first_out, 4);
    chk("b2b_b_addr", addr_err, 0);
    chk("b2b_b_cap", cap_err, 0);

    // Reset mid-stream, then stale and stray returns must be dropped.
    @(negedge clk); #1;
    clear_stats(27'h800, 27'd16, 6, 1'b0);
    bus.dma_engineer_req        = 1'b1;
    bus.dma_engineer_start_addr = 27'h800;
    bus.dma_engineer_length     = 27'd16;
    @(negedge clk); #1;
    bus.dma_engineer_req = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("rst_streaming", words > 0, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk_outputs_zero("rst_mid");
    snap_words = words;
    snap_iss   = iss;
    inj_cnt    = 3;
    repeat (15) @(negedge clk);
    #1;
    chk("rst_stray_dropped", words - snap_words, 0);
    chk("rst_no_reads", iss - snap_iss, 0);
    chk("rst_queue_drained", q_due.size(), 0);
    tb_out = 0;

    // Recovery: a normal transfer after the reset.
    run_vec(7, vt[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
